// File: rtl/text_row_buffer_pkg.sv
// Shared constants and byte decoding for the UART text display path.
package text_pkg;

  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_DEL   = 8'h7F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  localparam int unsigned MODE_WRAP   = 0;
  localparam int unsigned MODE_SCROLL = 1;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_PRINT,
    CMD_BACK,
    CMD_HOME,
    CMD_WIPE
  } cmd_e;

  // Classify a received byte into the edit it requests.
  function automatic cmd_e decodeByte(input logic [7:0] b);
    if (b >= PRINT_MIN && b <= PRINT_MAX) return CMD_PRINT;
    if (b == ASCII_BS || b == ASCII_DEL)  return CMD_BACK;
    if (b == ASCII_CR)                    return CMD_HOME;
    if (b == ASCII_LF)                    return CMD_WIPE;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/text_row_buffer_if.sv
// Byte input, clear and read-port bundle between UART receiver / renderer and the row buffer.
interface text_row_buffer_if #(
  parameter int unsigned IDX_W = 4
);
  logic             byte_ready;
  logic [7:0]       data;
  logic             clear;
  logic [IDX_W-1:0] output_char_index;
  logic [7:0]       out_byte;
  logic [IDX_W:0]   cursor;
  logic             full;
  logic             changed;

  modport master (
    output byte_ready, data, clear, output_char_index,
    input  out_byte, cursor, full, changed
  );

  modport slave (
    input  byte_ready, data, clear, output_char_index,
    output out_byte, cursor, full, changed
  );
endinterface

// File: rtl/text_row_buffer_rise_detect.sv
// Rising-edge detector for a level-type ready flag; reset level chosen by the user.
module rise_detect #(
  parameter bit RESET_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise_c
);

  logic levelQ;

  // Remember last sampled level; resetting high suppresses a level already high at release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) levelQ <= RESET_LEVEL;
    else        levelQ <= level;
  end

  assign rise_c = level & ~levelQ;

endmodule

// File: rtl/text_row_buffer.sv
// Single character row edited by UART bytes, with registered indexed read-back.
module text_row_buffer
  import text_pkg::*;
#(
  parameter int unsigned CHARS  = 16,
  parameter int unsigned IDX_W  = $clog2(CHARS),
  parameter int unsigned SCROLL = MODE_WRAP
) (
  input logic          clk,
  input logic          rst_n,
  text_row_buffer_if.slave bus
);

  localparam int unsigned     CUR_W    = IDX_W + 1;
  localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(CHARS - 1);
  localparam logic [CUR_W-1:0] CUR_END  = CUR_W'(CHARS);

  logic             accept;
  cmd_e             cmd;
  logic [7:0]       rowQ [CHARS];
  logic [7:0]       rowD [CHARS];
  logic [CUR_W-1:0] curQ, curD;
  logic             fullQ, fullD;
  logic             changedQ, changedD;
  logic [7:0]       outByteQ, outByteD;

  rise_detect #(.RESET_LEVEL(1'b1)) uRise (
    .clk    (clk),
    .rst_n  (rst_n),
    .level  (bus.byte_ready),
    .rise_c (accept)
  );

  assign cmd = decodeByte(bus.data);

  // Next row/cursor from clear or the accepted byte; clear wins and discards the byte.
  always_comb begin
    rowD     = rowQ;
    curD     = curQ;
    changedD = 1'b0;
    if (bus.clear) begin
      for (int i = 0; i < int'(CHARS); i++) rowD[i] = ASCII_SPACE;
      curD     = '0;
      changedD = 1'b1;
    end else if (accept) begin
      case (cmd)
        CMD_PRINT: begin
          changedD = 1'b1;
          if (SCROLL == MODE_SCROLL && curQ == CUR_END) begin
            for (int i = 0; i < int'(CHARS) - 1; i++) rowD[i] = rowQ[i+1];
            rowD[CHARS-1] = bus.data;
          end else begin
            rowD[curQ[IDX_W-1:0]] = bus.data;
            curD = (SCROLL == MODE_WRAP && curQ == CUR_LAST) ? '0 : curQ + CUR_W'(1);
          end
        end
        CMD_BACK: begin
          if (curQ != '0) begin
            curD                  = curQ - CUR_W'(1);
            rowD[curD[IDX_W-1:0]] = ASCII_SPACE;
            changedD              = 1'b1;
          end
        end
        CMD_HOME: begin
          curD     = '0;
          changedD = 1'b1;
        end
        CMD_WIPE: begin
          for (int i = 0; i < int'(CHARS); i++) rowD[i] = ASCII_SPACE;
          curD     = '0;
          changedD = 1'b1;
        end
        default: ;
      endcase
    end
    fullD    = (SCROLL == MODE_SCROLL) && (curD == CUR_END);
    outByteD = (32'(bus.output_char_index) < CHARS) ? rowQ[bus.output_char_index] : ASCII_SPACE;
  end

  // Row, cursor, status and read-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CHARS); i++) rowQ[i] <= ASCII_SPACE;
      curQ     <= '0;
      fullQ    <= 1'b0;
      changedQ <= 1'b0;
      outByteQ <= ASCII_SPACE;
    end else begin
      rowQ     <= rowD;
      curQ     <= curD;
      fullQ    <= fullD;
      changedQ <= changedD;
      outByteQ <= outByteD;
    end
  end

  assign bus.out_byte = outByteQ;
  assign bus.cursor   = curQ;
  assign bus.full     = fullQ;
  assign bus.changed  = changedQ;

endmodule
